// File: rtl/vs2_bus_pkg.sv
// Shared definitions for the vs2 CPU bus: access FSM states and the default
// address map (ROM, RAM, VRAM and the console byte sink).
package vs2_bus_pkg;

  localparam int MAX_REGIONS = 8;
  localparam int IDX_W       = $clog2(MAX_REGIONS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CONSOLE,
    ST_DONE,
    ST_ERR
  } bus_state_e;

  localparam logic [23:0] ROM_BASE  = 24'h000000;
  localparam logic [23:0] ROM_MASK  = 24'hF00000;
  localparam logic [23:0] RAM_BASE  = 24'h600000;
  localparam logic [23:0] RAM_MASK  = 24'hE00000;
  localparam logic [23:0] VRAM_BASE = 24'hC00000;
  localparam logic [23:0] VRAM_MASK = 24'hF00000;

  localparam logic [23:0] DEFAULT_CONSOLE_ADDR = 24'h2000FC;

  // Packed region 3..0, region 0 in the least significant slice.
  localparam logic [95:0] DEFAULT_REGION_BASE = {VRAM_BASE, RAM_BASE, ROM_BASE, ROM_BASE};
  localparam logic [95:0] DEFAULT_REGION_MASK = {VRAM_MASK, RAM_MASK, ROM_MASK, ROM_MASK};
  localparam logic [15:0] DEFAULT_REGION_WAIT = {4'd2, 4'd2, 4'd2, 4'd2};

endpackage

// File: rtl/region_decoder.sv
// Combinational priority decode of a 24-bit address against the region map;
// the lowest matching region index wins.
module region_decoder
  import vs2_bus_pkg::*;
#(
  parameter int                        NUM_REGIONS = 4,
  parameter logic [NUM_REGIONS*24-1:0] REGION_BASE = '0,
  parameter logic [NUM_REGIONS*24-1:0] REGION_MASK = '0
) (
  input  logic [23:0]      addr,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    hit = 1'b0;
    idx = '0;
    // Scan downward so the lowest matching index is the last one written.
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if ((addr & REGION_MASK[i*24 +: 24]) == (REGION_BASE[i*24 +: 24] & REGION_MASK[i*24 +: 24])) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/mem_region_mux.sv
// CPU bus front end: decodes each request to a wait-stated region, the console
// byte sink, or a bus error, and returns a single-cycle cpu_ready completion.
module mem_region_mux
  import vs2_bus_pkg::*;
#(
  parameter int                        NUM_REGIONS  = 4,
  parameter int                        DATA_WIDTH   = 32,
  parameter logic [NUM_REGIONS*24-1:0] REGION_BASE  = DEFAULT_REGION_BASE,
  parameter logic [NUM_REGIONS*24-1:0] REGION_MASK  = DEFAULT_REGION_MASK,
  parameter logic [NUM_REGIONS*4-1:0]  REGION_WAIT  = DEFAULT_REGION_WAIT,
  parameter logic [23:0]               CONSOLE_ADDR = DEFAULT_CONSOLE_ADDR
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              cpu_valid,
  output logic                              cpu_ready,
  input  logic [31:0]                       cpu_addr,
  input  logic [DATA_WIDTH-1:0]             cpu_wdata,
  input  logic [DATA_WIDTH/8-1:0]           cpu_wstrb,
  output logic [DATA_WIDTH-1:0]             cpu_rdata,
  output logic [NUM_REGIONS-1:0]            region_sel,
  output logic [DATA_WIDTH/8-1:0]           region_wstrb,
  input  logic [NUM_REGIONS*DATA_WIDTH-1:0] region_rdata,
  output logic                              console_valid,
  output logic [7:0]                        console_data,
  input  logic                              console_ready,
  output logic                              bus_err,
  output logic [23:0]                       err_addr,
  output logic [7:0]                        err_count
);

  localparam int STRB_W = DATA_WIDTH / 8;

  bus_state_e        state;
  logic [3:0]        cnt;
  logic [IDX_W-1:0]  sel_idx;
  logic [STRB_W-1:0] wstrb_q;

  logic              dec_hit;
  logic [IDX_W-1:0]  dec_idx;
  logic [3:0]        dec_wait;
  logic              console_hit;
  logic              unused_bits;

  region_decoder #(
    .NUM_REGIONS (NUM_REGIONS),
    .REGION_BASE (REGION_BASE),
    .REGION_MASK (REGION_MASK)
  ) u_decoder (
    .addr (cpu_addr[23:0]),
    .hit  (dec_hit),
    .idx  (dec_idx)
  );

  assign dec_wait    = REGION_WAIT[dec_idx*4 +: 4];
  assign console_hit = (cpu_addr[23:0] == CONSOLE_ADDR) && cpu_wstrb[0];
  assign unused_bits = &{1'b0, cpu_addr[31:24], cpu_wdata[DATA_WIDTH-1:8]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      sel_idx      <= '0;
      wstrb_q      <= '0;
      region_sel   <= '0;
      console_data <= '0;
      err_addr     <= '0;
      err_count    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state)
        ST_IDLE: begin
          if (cpu_valid) begin
            if (console_hit) begin
              console_data <= cpu_wdata[7:0];
              state        <= ST_CONSOLE;
            end else if (dec_hit) begin
              sel_idx    <= dec_idx;
              region_sel <= NUM_REGIONS'(1) << dec_idx;
              wstrb_q    <= cpu_wstrb;
              cnt        <= dec_wait;
              state      <= (dec_wait == 4'd0) ? ST_DONE : ST_WAIT;
            end else begin
              err_addr <= cpu_addr[23:0];
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
              state    <= ST_ERR;
            end
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= ST_DONE;
        end
        ST_CONSOLE: begin
          if (console_ready) state <= ST_DONE;
        end
        ST_DONE: begin
          region_sel <= '0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Side-effecting strobes are gated by reset so a reset landing in DONE or
  // CONSOLE cannot leak a write or a console byte during the reset cycle.
  always_comb begin
    cpu_ready     = (state == ST_DONE) || (state == ST_ERR);
    bus_err       = (state == ST_ERR);
    console_valid = (state == ST_CONSOLE) && !reset;
    region_wstrb  = '0;
    cpu_rdata     = '0;
    if (state == ST_DONE && |region_sel) begin
      cpu_rdata = region_rdata[sel_idx*DATA_WIDTH +: DATA_WIDTH];
      if (!reset) region_wstrb = wstrb_q;
    end
  end

endmodule

// File: tb/tb_mem_region_mux.sv
// Directed bench for mem_region_mux: default map instance plus a two-region
// instance with a zero-wait RAM region at 600000h.
module tb_mem_region_mux;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic [3:0]   cpu_wstrb;
  logic         console_ready;

  logic         valid_a, ready_a, console_valid_a, bus_err_a;
  logic [31:0]  rdata_a;
  logic [3:0]   sel_a, wstrb_a;
  logic [127:0] region_rdata_a;
  logic [7:0]   console_data_a, err_count_a;
  logic [23:0]  err_addr_a;

  logic         valid_b, ready_b, console_valid_b, bus_err_b;
  logic [31:0]  rdata_b;
  logic [1:0]   sel_b;
  logic [3:0]   wstrb_b;
  logic [63:0]  region_rdata_b;
  logic [7:0]   console_data_b, err_count_b;
  logic [23:0]  err_addr_b;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_region_mux dut_a (
    .clk (clk), .reset (reset), .cpu_valid (valid_a), .cpu_ready (ready_a),
    .cpu_addr (cpu_addr), .cpu_wdata (cpu_wdata), .cpu_wstrb (cpu_wstrb), .cpu_rdata (rdata_a),
    .region_sel (sel_a), .region_wstrb (wstrb_a), .region_rdata (region_rdata_a),
    .console_valid (console_valid_a), .console_data (console_data_a), .console_ready (console_ready),
    .bus_err (bus_err_a), .err_addr (err_addr_a), .err_count (err_count_a)
  );

  mem_region_mux #(
    .NUM_REGIONS (2),
    .DATA_WIDTH  (32),
    .REGION_BASE ({24'h600000, 24'h000000}),
    .REGION_MASK ({24'hE00000, 24'hF00000}),
    .REGION_WAIT ({4'd0, 4'd2})
  ) dut_b (
    .clk (clk), .reset (reset), .cpu_valid (valid_b), .cpu_ready (ready_b),
    .cpu_addr (cpu_addr), .cpu_wdata (cpu_wdata), .cpu_wstrb (cpu_wstrb), .cpu_rdata (rdata_b),
    .region_sel (sel_b), .region_wstrb (wstrb_b), .region_rdata (region_rdata_b),
    .console_valid (console_valid_b), .console_data (console_data_b), .console_ready (console_ready),
    .bus_err (bus_err_b), .err_addr (err_addr_b), .err_count (err_count_b)
  );

  // Runs one access on the chosen instance and records what the bus did.
  // With hold set, cpu_valid stays high after completion (back-to-back).
  task automatic access(input bit on_b, input bit hold, input logic [23:0] addr,
                        input logic [31:0] wd, input logic [3:0] ws,
                        output int lat, output logic [31:0] rd, output logic [3:0] sel,
                        output int strb_cycles, output logic [3:0] strb_val, output int err_pulses);
    logic rdy, err;
    logic [3:0] strb;
    cpu_addr  = {8'hA5, addr};
    cpu_wdata = wd;
    cpu_wstrb = ws;
    if (on_b) valid_b = 1'b1; else valid_a = 1'b1;
    lat = 0; rd = '0; sel = '0; strb_cycles = 0; strb_val = '0; err_pulses = 0;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(negedge clk);
      rdy  = on_b ? ready_b : ready_a;
      err  = on_b ? bus_err_b : bus_err_a;
      strb = on_b ? wstrb_b : wstrb_a;
      if (strb != 4'd0) begin strb_cycles++; strb_val = strb; end
      if (err) err_pulses++;
      if (rdy) begin
        lat = c;
        rd  = on_b ? rdata_b : rdata_a;
        sel = on_b ? {2'b00, sel_b} : sel_a;
      end
    end
    if (!hold) begin
      valid_a = 1'b0; valid_b = 1'b0; cpu_wstrb = '0;
      @(negedge clk);
      strb = on_b ? wstrb_b : wstrb_a;
      if (strb != 4'd0) strb_cycles++;
      if (on_b ? bus_err_b : bus_err_a) err_pulses++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_total++; if (ready_a !== 1'b0) $display("FAIL reset_ready: got %b, expected 0", ready_a); else n_pass++;
    n_total++; if (sel_a !== 4'd0) $display("FAIL reset_sel: got %b, expected 0000", sel_a); else n_pass++;
    n_total++; if ({wstrb_a, console_valid_a, bus_err_a} !== 6'd0) $display("FAIL reset_strobes: got %b, expected 0", {wstrb_a, console_valid_a, bus_err_a}); else n_pass++;
    n_total++; if ({rdata_a, console_data_a} !== 40'd0) $display("FAIL reset_data: got %h, expected 0", {rdata_a, console_data_a}); else n_pass++;
    n_total++; if ({err_addr_a, err_count_a} !== 32'd0) $display("FAIL reset_err_regs: got %h, expected 0", {err_addr_a, err_count_a}); else n_pass++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_region_read();
    int lat, sc, ep; logic [31:0] rd; logic [3:0] sel, sv;
    access(1'b0, 1'b0, 24'h000010, 32'h0, 4'b0000, lat, rd, sel, sc, sv, ep);
    n_total++; if (lat !== 3) $display("FAIL read_latency: got %0d, expected 3", lat); else n_pass++;
    n_total++; if (rd !== 32'hDEADBEEF) $display("FAIL read_rdata: got %h, expected deadbeef", rd); else n_pass++;
    n_total++; if (sel !== 4'b0001) $display("FAIL read_sel: got %b, expected 0001", sel); else n_pass++;
    n_total++; if (sc !== 0) $display("FAIL read_no_wstrb: got %0d strobe cycles, expected 0", sc); else n_pass++;
    n_total++; if ({ready_a, sel_a, rdata_a} !== 37'd0) $display("FAIL read_idle_after: got %h, expected 0", {ready_a, sel_a, rdata_a}); else n_pass++;
  endtask

  task automatic test_overlap();
    int lat, sc, ep; logic [31:0] rd; logic [3:0] sel, sv;
    access(1'b0, 1'b0, 24'h000100, 32'h0, 4'b0000, lat, rd, sel, sc, sv, ep);
    n_total++; if (sel !== 4'b0001) $display("FAIL overlap_sel: got %b, expected 0001", sel); else n_pass++;
    n_total++; if (rd !== 32'hDEADBEEF) $display("FAIL overlap_rdata: got %h, expected deadbeef", rd); else n_pass++;
  endtask

  task automatic test_region_map();
    int lat, sc, ep; logic [31:0] rd; logic [3:0] sel, sv;
    access(1'b0, 1'b0, 24'h600004, 32'h0, 4'b0000, lat, rd, sel, sc, sv, ep);
    n_total++; if ({sel, rd} !== {4'b0100, 32'h22222222}) $display("FAIL ram_read: got %h, expected 422222222", {sel, rd}); else n_pass++;
    access(1'b0, 1'b0, 24'hC00020, 32'h5A5A5A5A, 4'b1100, lat, rd, sel, sc, sv, ep);
    n_total++; if (sel !== 4'b1000) $display("FAIL vram_write_sel: got %b, expected 1000", sel); else n_pass++;
    n_total++; if ({sc, sv} !== {32'd1, 4'b1100}) $display("FAIL vram_write_strb: got %0d cycles %b, expected 1 cycle 1100", sc, sv); else n_pass++;
    n_total++; if (rd !== 32'h33333333) $display("FAIL vram_write_rdata: got %h, expected 33333333", rd); else n_pass++;
    // Zero-wait region on the second instance.
    access(1'b1, 1'b0, 24'h600004, 32'h12345678, 4'b0011, lat, rd, sel, sc, sv, ep);
    n_total++; if (lat !== 1) $display("FAIL w0_latency: got %0d, expected 1", lat); else n_pass++;
    n_total++; if ({sc, sv} !== {32'd1, 4'b0011}) $display("FAIL w0_strb: got %0d cycles %b, expected 1 cycle 0011", sc, sv); else n_pass++;
    n_total++; if (sel !== 4'b0010) $display("FAIL w0_sel: got %b, expected 0010", sel); else n_pass++;
    access(1'b1, 1'b0, 24'h000020, 32'h0, 4'b0000, lat, rd, sel, sc, sv, ep);
    n_total++; if ({lat, rd} !== {32'd3, 32'hB0B0B0B0}) $display("FAIL b_rom_read: got %0d %h, expected 3 b0b0b0b0", lat, rd); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat, sc, ep; logic [31:0] rd; logic [3:0] sel, sv;
    access(1'b0, 1'b1, 24'h600000, 32'h0, 4'b0000, lat, rd, sel, sc, sv, ep);
    n_total++; if ({lat, rd} !== {32'd3, 32'h22222222}) $display("FAIL b2b_first: got %0d %h, expected 3 22222222", lat, rd); else n_pass++;
    // Counted from the DONE cycle: one IDLE acceptance cycle plus W+1.
    access(1'b0, 1'b0, 24'h000010, 32'h0, 4'b0000, lat, rd, sel, sc, sv, ep);
    n_total++; if ({lat, rd} !== {32'd4, 32'hDEADBEEF}) $display("FAIL b2b_second: got %0d %h, expected 4 deadbeef", lat, rd); else n_pass++;
  endtask

  task automatic test_console();
    int lat, nvalid;
    lat = 0; nvalid = 0;
    console_ready = 1'b0;
    cpu_addr = 32'h002000FC; cpu_wdata = 32'hFFFFFF41; cpu_wstrb = 4'b0001; valid_a = 1'b1;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(negedge clk);
      if (ready_a) lat = c;
      else if (console_valid_a && console_data_a == 8'h41 && !console_ready) nvalid++;
      if (c == 5) console_ready = 1'b1;
    end
    n_total++; if (nvalid !== 5) $display("FAIL console_valid_cycles: got %0d, expected 5", nvalid); else n_pass++;
    n_total++; if (lat !== 6) $display("FAIL console_ready_latency: got %0d, expected 6", lat); else n_pass++;
    n_total++; if ({console_valid_a, rdata_a, wstrb_a} !== 37'd0) $display("FAIL console_done_outputs: got %h, expected 0", {console_valid_a, rdata_a, wstrb_a}); else n_pass++;
    valid_a = 1'b0; cpu_wstrb = '0; console_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unmapped();
    int lat, sc, ep, total_err, bad;
    logic [31:0] rd; logic [3:0] sel, sv;
    total_err = 0; bad = 0;
    access(1'b0, 1'b0, 24'h400000, 32'h0, 4'b0000, lat, rd, sel, sc, sv, ep);
    n_total++; if ({lat, ep, err_count_a} !== {32'd1, 32'd1, 8'h01}) $display("FAIL err_first: got lat %0d pulses %0d count %h, expected 1 1 01", lat, ep, err_count_a); else n_pass++;
    for (int i = 1; i < 300; i++) begin
      access(1'b0, 1'b0, 24'h400000, 32'h0, 4'b0000, lat, rd, sel, sc, sv, ep);
      total_err += ep;
      if (lat != 1 || rd != 32'd0 || sel != 4'd0) bad++;
    end
    n_total++; if (total_err !== 299) $display("FAIL err_pulses: got %0d, expected 299", total_err); else n_pass++;
    n_total++; if (bad !== 0) $display("FAIL err_completions: got %0d bad, expected 0", bad); else n_pass++;
    n_total++; if ({err_addr_a, err_count_a} !== {24'h400000, 8'hFF}) $display("FAIL err_saturate: got %h, expected 400000ff", {err_addr_a, err_count_a}); else n_pass++;
    // A read of the console address is not a console write and is unmapped.
    access(1'b0, 1'b0, 24'h2000FC, 32'h0, 4'b0000, lat, rd, sel, sc, sv, ep);
    n_total++; if ({ep, err_addr_a, err_count_a} !== {32'd1, 24'h2000FC, 8'hFF}) $display("FAIL console_read_err: got %0d %h, expected 1 2000fcff", ep, {err_addr_a, err_count_a}); else n_pass++;
  endtask

  task automatic test_reset_mid_access();
    int strb_seen;
    strb_seen = 0;
    cpu_addr = 32'h00C00000; cpu_wdata = 32'h0; cpu_wstrb = 4'b1111; valid_a = 1'b1;
    @(negedge clk);
    reset = 1'b1; valid_a = 1'b0; cpu_wstrb = '0;
    @(negedge clk);
    n_total++; if ({ready_a, sel_a, wstrb_a, bus_err_a} !== 10'd0) $display("FAIL rst_wait_outputs: got %b, expected 0", {ready_a, sel_a, wstrb_a, bus_err_a}); else n_pass++;
    n_total++; if ({err_addr_a, err_count_a, rdata_a} !== 64'd0) $display("FAIL rst_wait_regs: got %h, expected 0", {err_addr_a, err_count_a, rdata_a}); else n_pass++;
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (wstrb_a != 4'd0 || ready_a) strb_seen++;
    end
    n_total++; if (strb_seen !== 0) $display("FAIL rst_wait_no_write: got %0d cycles, expected 0", strb_seen); else n_pass++;
    // Reset arriving in the DONE cycle must suppress the write in that cycle.
    cpu_wstrb = 4'b1111; valid_a = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1; valid_a = 1'b0; cpu_wstrb = '0;
    #1;
    n_total++; if (wstrb_a !== 4'd0) $display("FAIL rst_done_wstrb: got %b, expected 0000", wstrb_a); else n_pass++;
    @(negedge clk);
    n_total++; if ({ready_a, sel_a} !== 5'd0) $display("FAIL rst_done_after: got %b, expected 0", {ready_a, sel_a}); else n_pass++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; valid_a = 1'b0; valid_b = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0; console_ready = 1'b0;
    region_rdata_a = {32'h33333333, 32'h22222222, 32'hCAFEF00D, 32'hDEADBEEF};
    region_rdata_b = {32'hB1B1B1B1, 32'hB0B0B0B0};
    test_reset();
    test_region_read();
    test_overlap();
    test_region_map();
    test_back_to_back();
    test_console();
    test_unmapped();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
